// File: rtl/dma_pkg.sv
// Definitions shared by the CI DMA read and write engines: FSM state
// encoding and bus word constants.
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQUEST = 3'd1,
    ST_BEGIN   = 3'd2,
    ST_DATA    = 3'd3,
    ST_END     = 3'd4,
    ST_ERROR   = 3'd5
  } dma_state_t;

  localparam int         BUS_WORD_BYTES = 4;
  localparam logic [3:0] BYTE_EN_ALL    = 4'hF;

endpackage

// File: rtl/dma_bus_writer_if.sv
// Shared-bus signal bundle between a bus master (DMA engine) and the
// bus/arbiter side.
interface dma_bus_writer_if;

  // Handshake: request is held until granted is seen; the master then
  // drives one begin cycle, then beats. A beat transfers in any cycle
  // where data_valid_out && !busy_in; while busy_in is high the master
  // holds the beat and its data. error_in aborts the burst.
  logic        request;
  logic        granted;
  logic [31:0] address_data_out;
  logic [3:0]  byte_enables_out;
  logic [7:0]  burst_size_out;
  logic        read_n_write_out;
  logic        begin_transaction_out;
  logic        end_transaction_out;
  logic        data_valid_out;
  logic        busy_in;
  logic        error_in;

  modport master (
    output request, address_data_out, byte_enables_out, burst_size_out,
           read_n_write_out, begin_transaction_out, end_transaction_out,
           data_valid_out,
    input  granted, busy_in, error_in
  );

  modport slave (
    input  request, address_data_out, byte_enables_out, burst_size_out,
           read_n_write_out, begin_transaction_out, end_transaction_out,
           data_valid_out,
    output granted, busy_in, error_in
  );

endinterface

// File: rtl/dma_burst_counter.sv
// Sizes the next burst (min of burst_size+1 and remaining words) and
// counts accepted beats within the current burst.
module dma_burst_counter #(
  parameter int BLK_W = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             beat_accept,
  input  logic [BLK_W-1:0] remaining,
  input  logic [7:0]       burst_size,
  output logic [7:0]       burst_m1,
  output logic             last_beat
);

  localparam int CW = (BLK_W > 9) ? BLK_W : 9;

  logic [CW-1:0] want;
  logic [CW-1:0] have;
  logic [CW-1:0] beats;
  logic [7:0]    len_m1;
  logic [7:0]    beat_cnt;

  // beats never exceeds 256, so beats-1 always fits in 8 bits
  assign want     = CW'(burst_size) + CW'(1);
  assign have     = CW'(remaining);
  assign beats    = (want < have) ? want : have;
  assign burst_m1 = 8'(beats - CW'(1));

  assign last_beat = (beat_cnt == len_m1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_m1   <= '0;
      beat_cnt <= '0;
    end else if (load) begin
      len_m1   <= burst_m1;
      beat_cnt <= '0;
    end else if (beat_accept) begin
      beat_cnt <= beat_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/dma_bus_writer.sv
// Write-direction DMA: streams SSRAM words onto the shared bus as bursts.
// Optional DMA_WRITER_STALL_COUNT_EN adds a saturating stall_count output.
module dma_bus_writer
  import dma_pkg::*;
#(
  parameter int MEM_AW = 9,
  parameter int BLK_W  = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       bus_start_address,
  input  logic [MEM_AW-1:0] memory_start_address,
  input  logic [BLK_W-1:0]  block_size,
  input  logic [7:0]        burst_size,
  output logic [MEM_AW-1:0] mem_address,
  input  logic [31:0]       mem_data,
  output logic              busy,
  output logic              error,
  output logic              done,
  dma_bus_writer_if.master  bus,
  output dma_state_t        dbg_state
`ifdef DMA_WRITER_STALL_COUNT_EN
  ,
  output logic [15:0]       stall_count
`endif
);

  dma_state_t        state;
  logic [31:0]       bus_addr;
  logic [MEM_AW-1:0] mem_addr;
  logic [BLK_W-1:0]  remaining;
  logic [7:0]        cfg_burst;

  logic        request_q;
  logic        begin_q;
  logic        end_q;
  logic        valid_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [7:0]  bsz_q;
  logic        busy_q;
  logic        error_q;
  logic        done_q;

  logic       beat_accept;
  logic       load_burst;
  logic [7:0] burst_m1;
  logic       last_beat;

  // An erroring beat is discarded, so it never advances the addresses
  assign beat_accept = valid_q & ~bus.busy_in & ~bus.error_in;
  assign load_burst  = (state == ST_REQUEST) & bus.granted;

  // Read one word ahead on acceptance so mem_data tracks the current beat
  assign mem_address = mem_addr + MEM_AW'(beat_accept);

  assign bus.request               = request_q;
  assign bus.address_data_out      = valid_q ? mem_data : addr_q;
  assign bus.byte_enables_out      = be_q;
  assign bus.burst_size_out        = bsz_q;
  assign bus.read_n_write_out      = 1'b0;
  assign bus.begin_transaction_out = begin_q;
  assign bus.end_transaction_out   = end_q;
  assign bus.data_valid_out        = valid_q;

  assign busy      = busy_q;
  assign error     = error_q;
  assign done      = done_q;
  assign dbg_state = state;

  dma_burst_counter #(
    .BLK_W(BLK_W)
  ) u_burst_counter (
    .clock       (clock),
    .reset       (reset),
    .load        (load_burst),
    .beat_accept (beat_accept),
    .remaining   (remaining),
    .burst_size  (cfg_burst),
    .burst_m1    (burst_m1),
    .last_beat   (last_beat)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      bus_addr  <= '0;
      mem_addr  <= '0;
      remaining <= '0;
      cfg_burst <= '0;
      request_q <= 1'b0;
      begin_q   <= 1'b0;
      end_q     <= 1'b0;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      bsz_q     <= '0;
      busy_q    <= 1'b0;
      error_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      begin_q <= 1'b0;
      end_q   <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            bus_addr  <= {bus_start_address[31:2], 2'b00};
            mem_addr  <= memory_start_address;
            remaining <= block_size;
            cfg_burst <= burst_size;
            error_q   <= 1'b0;
            if (block_size == '0) begin
              done_q <= 1'b1;
            end else begin
              request_q <= 1'b1;
              busy_q    <= 1'b1;
              state     <= ST_REQUEST;
            end
          end
        end
        ST_REQUEST: begin
          if (bus.granted) begin
            request_q <= 1'b0;
            begin_q   <= 1'b1;
            addr_q    <= bus_addr;
            be_q      <= BYTE_EN_ALL;
            bsz_q     <= burst_m1;
            state     <= ST_BEGIN;
          end
        end
        ST_BEGIN: begin
          addr_q <= '0;
          be_q   <= '0;
          bsz_q  <= '0;
          if (bus.error_in) begin
            end_q   <= 1'b1;
            error_q <= 1'b1;
            done_q  <= 1'b1;
            state   <= ST_ERROR;
          end else begin
            valid_q <= 1'b1;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bus.error_in) begin
            valid_q <= 1'b0;
            end_q   <= 1'b1;
            error_q <= 1'b1;
            done_q  <= 1'b1;
            state   <= ST_ERROR;
          end else if (!bus.busy_in) begin
            bus_addr  <= bus_addr + 32'(BUS_WORD_BYTES);
            mem_addr  <= mem_addr + MEM_AW'(1);
            remaining <= remaining - BLK_W'(1);
            if (last_beat) begin
              valid_q <= 1'b0;
              end_q   <= 1'b1;
              done_q  <= (remaining == BLK_W'(1));
              state   <= ST_END;
            end
          end
        end
        ST_END: begin
          if (remaining != '0) begin
            request_q <= 1'b1;
            state     <= ST_REQUEST;
          end else begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        ST_ERROR: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef DMA_WRITER_STALL_COUNT_EN
  logic [15:0] stall_q;

  assign stall_count = stall_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if ((state == ST_IDLE) && start) begin
      stall_q <= '0;
    end else if (valid_q && bus.busy_in && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dma_bus_writer.sv
// Bench for dma_bus_writer: a bus-slave driver with random grant/stall,
// an SSRAM model and burst/beat scoreboards (DMA_WRITER_STALL_COUNT_EN aware).
module tb_dma_bus_writer;
  import dma_pkg::*;

  localparam int MEM_AW = 9;
  localparam int BLK_W  = 10;

  logic              clock;
  logic              reset;
  logic              start;
  logic [31:0]       bus_start_address;
  logic [MEM_AW-1:0] memory_start_address;
  logic [BLK_W-1:0]  block_size;
  logic [7:0]        burst_size;
  logic [MEM_AW-1:0] mem_address;
  logic [31:0]       mem_data;
  logic              busy;
  logic              error;
  logic              done;
  dma_state_t        dbg_state;
`ifdef DMA_WRITER_STALL_COUNT_EN
  logic [15:0]       stall_count;
`endif

  dma_bus_writer_if bus ();

  dma_bus_writer #(
    .MEM_AW(MEM_AW),
    .BLK_W (BLK_W)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .start                (start),
    .bus_start_address    (bus_start_address),
    .memory_start_address (memory_start_address),
    .block_size           (block_size),
    .burst_size           (burst_size),
    .mem_address          (mem_address),
    .mem_data             (mem_data),
    .busy                 (busy),
    .error                (error),
    .done                 (done),
    .bus                  (bus),
    .dbg_state            (dbg_state)
`ifdef DMA_WRITER_STALL_COUNT_EN
    ,
    .stall_count          (stall_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read SSRAM, one cycle of latency
  logic [31:0] ssram [512];
  always @(posedge clock) mem_data <= ssram[mem_address];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_bsz_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_bus"}, {bus.request, bus.begin_transaction_out, bus.end_transaction_out,
                             bus.data_valid_out, bus.read_n_write_out, bus.byte_enables_out},
             32'd0);
    check_eq({tag, "_ad"}, bus.address_data_out, 32'd0);
    check_eq({tag, "_bsz"}, {24'd0, bus.burst_size_out}, 32'd0);
    check_eq({tag, "_flags"}, {busy, error, done}, 32'd0);
    check_eq({tag, "_maddr"}, mem_address, 32'd0);
    check_eq({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // ---------------- driver ----------------
  task automatic run_xfer(input logic [31:0] baddr, input int maddr, input int blk, input int bsz,
                          input int err_beat, input int stall_pct, input int grant_pct,
                          input int force_stall_beat, input int force_stall_len,
                          input int restart_at);
    logic [31:0] a;
    int rem, n, nb, cyc, beat_idx, stalls, waits, rises, busy_cycles, forced, exp_beats;
    bit finished, req_prev;
    exp_q.delete();
    exp_addr_q.delete();
    exp_bsz_q.delete();
    // Reference: split the block into bursts and list the words in bus order
    a = {baddr[31:2], 2'b00};
    rem = blk;
    nb = 0;
    while (rem > 0) begin
      n = (bsz + 1 < rem) ? bsz + 1 : rem;
      exp_addr_q.push_back(a);
      exp_bsz_q.push_back(32'(n - 1));
      a = a + 32'(4 * n);
      rem -= n;
      nb++;
    end
    for (int i = 0; i < blk; i++) exp_q.push_back(ssram[(maddr + i) % 512]);
    exp_beats = (err_beat >= 0) ? err_beat : blk;

    @(negedge clock);
    bus_start_address    = baddr;
    memory_start_address = MEM_AW'(maddr);
    block_size           = BLK_W'(blk);
    burst_size           = 8'(bsz);
    start                = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check_eq("err_clr", error, 1'b0);

    cyc = 0; beat_idx = 0; stalls = 0; waits = 0; rises = 0; busy_cycles = 0; forced = 0;
    finished = 1'b0; req_prev = 1'b0;
    while (!finished && cyc < 3000) begin
      // Slave decisions for the cycle ending at the next posedge
      if (cyc == restart_at) begin
        start                = 1'b1;
        bus_start_address    = $urandom;
        memory_start_address = MEM_AW'($urandom_range(0, 511));
        block_size           = BLK_W'($urandom_range(1, 50));
        burst_size           = 8'($urandom_range(0, 7));
      end else begin
        start = 1'b0;
      end
      bus.granted = bus.request && ($urandom_range(1, 100) <= grant_pct);
      bus.error_in = bus.data_valid_out && (beat_idx == err_beat);
      if (!bus.data_valid_out) begin
        bus.busy_in = 1'b0;
      end else if (beat_idx == force_stall_beat && forced < force_stall_len) begin
        bus.busy_in = 1'b1;
        forced++;
      end else begin
        bus.busy_in = ($urandom_range(1, 100) <= stall_pct);
      end
      #1;
      if (busy) busy_cycles++;
      if (bus.request && !bus.granted) waits++;
      if (bus.request && !req_prev) rises++;
      req_prev = bus.request;
      if (bus.begin_transaction_out) begin
        check_eq("req_drop", bus.request, 1'b0);
        if (exp_addr_q.size() == 0) begin
          check_eq("extra_begin", 1'b1, 1'b0);
        end else begin
          check_eq("burst_addr", bus.address_data_out, exp_addr_q.pop_front());
          check_eq("burst_size", {24'd0, bus.burst_size_out}, exp_bsz_q.pop_front());
          check_eq("byte_en", bus.byte_enables_out, BYTE_EN_ALL);
        end
      end
      if (bus.data_valid_out) begin
        if (bus.busy_in) stalls++;
        if (exp_q.size() == 0) begin
          check_eq("extra_beat", 1'b1, 1'b0);
        end else begin
          check_eq("beat_data", bus.address_data_out, exp_q[0]);
          if (!bus.busy_in && !bus.error_in) begin
            void'(exp_q.pop_front());
            beat_idx++;
          end
        end
      end
      if (done) begin
        finished = 1'b1;
        check_eq("done_end", bus.end_transaction_out, blk != 0);
        check_eq("done_err", error, err_beat >= 0);
        check_eq("beats", beat_idx, exp_beats);
        if (err_beat < 0) begin
          check_eq("bursts_left", exp_addr_q.size(), 0);
          check_eq("req_count", rises, nb);
        end
        if (blk == 0) check_eq("zero_busy", busy, 1'b0);
        else if (err_beat < 0)
          check_eq("busy_cycles", busy_cycles, 3 * nb + blk + stalls + waits);
      end
      @(negedge clock);
      cyc++;
    end
    start        = 1'b0;
    bus.granted  = 1'b0;
    bus.busy_in  = 1'b0;
    bus.error_in = 1'b0;
    if (!finished) check_eq("timeout", 1'b0, 1'b1);
    check_eq("idle_after", dbg_state, ST_IDLE);
    check_eq("busy_after", busy, 1'b0);
`ifdef DMA_WRITER_STALL_COUNT_EN
    check_eq("stall_count", stall_count, stalls);
`endif
  endtask

  task automatic reset_mid_data();
    int cyc;
    @(negedge clock);
    bus_start_address    = 32'h2000;
    memory_start_address = '0;
    block_size           = BLK_W'(8);
    burst_size           = 8'd7;
    start                = 1'b1;
    @(negedge clock);
    start       = 1'b0;
    bus.granted = 1'b1;
    cyc = 0;
    while (!bus.data_valid_out && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    check_eq("reach_data", bus.data_valid_out, 1'b1);
    @(negedge clock);
    #1 reset = 1'b0;
    #1;
    check_all_zero("rst_mid");
    bus.granted = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_eq("rst_idle", dbg_state, ST_IDLE);
    check_eq("rst_busy", busy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset                = 1'b0;
    start                = 1'b0;
    bus_start_address    = '0;
    memory_start_address = '0;
    block_size           = '0;
    burst_size           = '0;
    bus.granted          = 1'b0;
    bus.busy_in          = 1'b0;
    bus.error_in         = 1'b0;
    for (int i = 0; i < 512; i++) ssram[i] = $urandom;
    ssram[0] = 32'hAAAA_0000;
    ssram[1] = 32'hBBBB_1111;
    ssram[2] = 32'hCCCC_2222;
    ssram[3] = 32'hDDDD_3333;

    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b1;

    // baddr, maddr, blk, bsz, err, stall%, grant%, fbeat, flen, restart
    run_xfer(32'h1000, 0, 4, 3, -1, 0, 100, -1, 0, -1);     // basic
    run_xfer(32'h1000, 0, 10, 3, -1, 0, 100, -1, 0, -1);    // 3,3,1 split
    run_xfer(32'h1000, 0, 4, 3, -1, 0, 100, 2, 2, -1);      // forced stall
    run_xfer(32'h4000, 20, 8, 7, 1, 0, 100, -1, 0, -1);     // error on beat 1
    run_xfer(32'h1003, 0, 4, 3, -1, 0, 100, -1, 0, -1);     // clears error, low bits
    run_xfer(32'h8000, 510, 4, 7, -1, 0, 100, -1, 0, -1);   // SSRAM wrap
    run_xfer(32'h9000, 5, 0, 3, -1, 0, 100, -1, 0, -1);     // zero length
    run_xfer(32'hFFFF_FFF0, 100, 9, 2, -1, 20, 70, -1, 0, 3); // bus wrap, start ignored
    reset_mid_data();
    run_xfer(32'h1000, 0, 4, 3, -1, 0, 100, -1, 0, -1);     // normal after reset

    for (int r = 0; r < 12; r++) begin
      automatic int blk = $urandom_range(1, 40);
      automatic int err = (r % 5 == 3) ? int'($urandom_range(0, blk - 1)) : -1;
      automatic logic [31:0] ba = (r % 4 == 0) ? (32'hFFFF_FFC0 | 32'($urandom_range(0, 63)))
                                               : $urandom;
      run_xfer(ba, $urandom_range(0, 511), blk, $urandom_range(0, 15), err,
               30, 60, -1, 0, (r % 3 == 1) ? 4 : -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
